ksa_checked_pipe: RTL and testbench

Parametrised, self-checking pipelined adder with valid/ready handshakes on both sides. A Kogge-Stone adder result is compared every cycle against an independent ripple-carry reference. On disagreement the block spends one recovery cycle and forwards the reference result, so downstream always receives a correct sum. It replaces the fixed 8-bit adder-plus-shadow-clock arrangement with a single-clock, width-generic unit. Mismatch pulse, saturating error counter and sticky flag are reported for characterisation.

---
 rtl/ksa_checked_pipe.sv | 186 ++++++++++++++++++
 tb/tb_ksa_checked_pipe.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ksa_checked_pipe.sv
// ksa_checked_pipe: two-stage valid/ready adder pipeline.
// A Kogge-Stone adder result is checked against a ripple-carry reference every cycle.
// On disagreement the block takes one recovery cycle and forwards the reference sum instead.
// Optional feature macro: KSA_CHECKED_PIPE_ERRCNT_EN instantiates the saturating err_cnt counter;
// when it is undefined, err_cnt is tied to zero.
module ksa_checked_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH:0]   fault_mask,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_sticky,
  input  logic             err_clr
);

  typedef enum logic {RUN, RECOVER} state_t;

  // Carry-in occupies extended position 0, so the prefix tree spans WIDTH+1 positions.
  localparam int EW     = WIDTH + 1;
  localparam int LEVELS = $clog2(EW);

  state_t state_q, state_d;

  logic [WIDTH-1:0] s1_a, s1_b;
  logic             s1_cin, s1_vld;
  logic             s1_load, s1_retire;
  logic             load_ksa, load_ref, go_recover;
  logic             s2_free, match;

  logic [EW-1:0]    gk [0:LEVELS];
  logic [EW-1:0]    pk [0:LEVELS-1];
  logic [WIDTH:0]   ksa_res, ref_res;
  logic [WIDTH-1:0] ref_sum;
  logic             ref_carry;

  // Kogge-Stone prefix tree.
  // After the last level, gk[LEVELS][i] is the carry into operand bit i.
  assign gk[0] = {s1_a & s1_b, s1_cin};
  assign pk[0] = {s1_a ^ s1_b, 1'b0};

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int D = 1 << l;
    assign gk[l+1] = gk[l] | (pk[l] & (gk[l] << D));
    if (l + 1 < LEVELS) begin : g_prop
      assign pk[l+1] = pk[l] & (pk[l] << D);
    end
  end

  assign ksa_res = {gk[LEVELS][EW-1], pk[0][EW-1:1] ^ gk[LEVELS][EW-2:0]} ^ fault_mask;

  // Independent ripple-carry reference used as the checker and the recovery source.
  always_comb begin
    ref_sum   = '0;
    ref_carry = s1_cin;
    for (int i = 0; i < WIDTH; i++) begin
      ref_sum[i] = s1_a[i] ^ s1_b[i] ^ ref_carry;
      ref_carry  = (s1_a[i] & s1_b[i]) | (ref_carry & (s1_a[i] ^ s1_b[i]));
    end
  end

  assign ref_res = {ref_carry, ref_sum};
  assign match   = (ksa_res == ref_res);
  assign s2_free = !out_vld || out_rdy;
  assign in_rdy  = !rst && (state_q == RUN) && (!s1_vld || (s2_free && match));
  assign s1_load = in_vld && in_rdy;

  // Next-state and stage-control decode.
  // A mismatch holds S1 and defers to RECOVER without re-comparing.
  always_comb begin
    state_d    = state_q;
    load_ksa   = 1'b0;
    load_ref   = 1'b0;
    s1_retire  = 1'b0;
    go_recover = 1'b0;
    case (state_q)
      RUN: begin
        if (s1_vld && s2_free) begin
          if (match) begin
            load_ksa  = 1'b1;
            s1_retire = 1'b1;
          end else begin
            go_recover = 1'b1;
            state_d    = RECOVER;
          end
        end
      end
      RECOVER: begin
        if (s2_free) begin
          load_ref  = 1'b1;
          s1_retire = 1'b1;
          state_d   = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Stage S1 operand register.
  // A retiring item may be replaced on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_cin <= 1'b0;
    end else if (s1_load) begin
      s1_vld <= 1'b1;
      s1_a   <= a;
      s1_b   <= b;
      s1_cin <= cin;
    end else if (s1_retire) begin
      s1_vld <= 1'b0;
    end
  end

  // Stage S2 result register.
  // Its contents hold while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (load_ksa) begin
      out_vld     <= 1'b1;
      {cout, sum} <= ksa_res;
    end else if (load_ref) begin
      out_vld     <= 1'b1;
      {cout, sum} <= ref_res;
    end else if (out_rdy) begin
      out_vld <= 1'b0;
    end
  end

  // Mismatch pulse and sticky flag.
  // A simultaneous event wins over a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch   <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      mismatch <= go_recover;
      if (go_recover)   err_sticky <= 1'b1;
      else if (err_clr) err_sticky <= 1'b0;
    end
  end

`ifdef KSA_CHECKED_PIPE_ERRCNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [CNT_W-1:0] cnt_q;

  // Saturating event counter.
  // A clear applies first, then a same-cycle event counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (err_clr) begin
      cnt_q <= go_recover ? CNT_W'(1) : '0;
    end else if (go_recover && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign err_cnt = cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_ksa_checked_pipe.sv
// Self-checking bench for ksa_checked_pipe (WIDTH=8, CNT_W=2).
// A transaction-level queue model predicts every output from a + b + cin.
module tb_ksa_checked_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a = '0, b = '0;
  logic       cin = 1'b0, in_vld = 1'b0, out_rdy = 1'b1, err_clr = 1'b0;
  logic [8:0] fault_mask = '0;
  logic       in_rdy, cout, out_vld, mismatch, err_sticky;
  logic [7:0] sum;
  logic [1:0] err_cnt;

  int checks = 0, errors = 0;
  int pops = 0, mm_seen = 0, exp_mm = 0, cnt_model = 0;
  logic sticky_model = 1'b0;
  logic [8:0] exp_q[$];

  ksa_checked_pipe #(.WIDTH(8), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .in_vld(in_vld), .in_rdy(in_rdy),
    .fault_mask(fault_mask), .sum(sum), .cout(cout), .out_vld(out_vld), .out_rdy(out_rdy),
    .mismatch(mismatch), .err_cnt(err_cnt), .err_sticky(err_sticky), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int expErrCnt();
`ifdef KSA_CHECKED_PIPE_ERRCNT_EN
    return cnt_model;
`else
    return 0;
`endif
  endfunction

  // Compare process: checks every valid output against the model queue.
  // It also records the transfers that will happen on the coming edge.
  initial forever begin
    @(negedge clk);
    #2;
    if (mismatch === 1'b1) mm_seen++;
    if (rst) begin
      checkOutput("in_rdy_during_reset", 32'(in_rdy), 0);
      exp_q.delete();
    end else begin
      if (out_vld) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got 0x%0h with nothing outstanding", {cout, sum});
        end else begin
          checkOutput("out_data", 32'({cout, sum}), 32'(exp_q[0]));
          if (out_rdy) begin
            void'(exp_q.pop_front());
            pops++;
          end
        end
      end
      if (in_vld && in_rdy) exp_q.push_back(9'(a) + 9'(b) + 9'(cin));
    end
  end

  // Drive one operand set; returns at the negedge after acceptance.
  task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                               output int waited);
    a = va; b = vb; cin = vc; in_vld = 1'b1; waited = 0;
    #1;
    while (!in_rdy && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_rdy) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: in_rdy stayed 0 for %0d cycles", waited);
      in_vld = 1'b0;
    end
    @(negedge clk);
  endtask

  // Single item with an injected fault; expects one recovery cycle.
  task automatic runFaulted(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                            input logic [8:0] mask, input logic clr, input logic [8:0] exp9);
    fault_mask = mask;
    a = va; b = vb; cin = vc; in_vld = 1'b1;
    #1 checkOutput("fault_in_rdy", 32'(in_rdy), 1);
    @(negedge clk);
    in_vld = 1'b0;
    if (clr) begin
      err_clr = 1'b1;
      cnt_model = 1;
    end else begin
      cnt_model = (cnt_model < 3) ? cnt_model + 1 : 3;
    end
    sticky_model = 1'b1;
    exp_mm++;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    checkOutput("fault_mismatch_pulse", 32'(mismatch), 1);
    checkOutput("fault_out_vld_delayed", 32'(out_vld), 0);
    @(negedge clk);
    #1;
    checkOutput("fault_mismatch_drop", 32'(mismatch), 0);
    checkOutput("fault_out_vld", 32'(out_vld), 1);
    checkOutput("fault_result", 32'({cout, sum}), 32'(exp9));
    checkOutput("fault_err_cnt", 32'(err_cnt), 32'(expErrCnt()));
    checkOutput("fault_err_sticky", 32'(err_sticky), 32'(sticky_model));
    fault_mask = '0;
    @(negedge clk);
  endtask

  // Wait, bounded, until every modelled item has left the pipe.
  task automatic waitDrain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      #3;
      n++;
    end
    checkOutput("drain_empty", 32'(exp_q.size()), 0);
    @(negedge clk);
  endtask

  initial begin
    int w;
    int p0;
    logic [7:0] ra, rb;
    logic rc;
    logic [8:0] masks [4];
    masks[0] = 9'h001;
    masks[1] = 9'h100;
    masks[2] = 9'h080;
    masks[3] = 9'h0F0;

    // Reset values.
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_out_vld", 32'(out_vld), 0);
    checkOutput("rst_sum", 32'(sum), 0);
    checkOutput("rst_cout", 32'(cout), 0);
    checkOutput("rst_mismatch", 32'(mismatch), 0);
    checkOutput("rst_err_cnt", 32'(err_cnt), 0);
    checkOutput("rst_err_sticky", 32'(err_sticky), 0);
    checkOutput("rst_in_rdy", 32'(in_rdy), 0);
    rst = 1'b0;
    @(negedge clk);

    // 0x5A + 0x3C + 1 = 0x097, visible two edges after accept.
    $display("[TB] directed add with latency check");
    a = 8'h5A; b = 8'h3C; cin = 1'b1; in_vld = 1'b1;
    #1 checkOutput("t1_in_rdy", 32'(in_rdy), 1);
    @(negedge clk);
    in_vld = 1'b0;
    #1 checkOutput("t1_out_vld_early", 32'(out_vld), 0);
    @(negedge clk);
    #1;
    checkOutput("t1_out_vld", 32'(out_vld), 1);
    checkOutput("t1_sum", 32'(sum), 32'h97);
    checkOutput("t1_cout", 32'(cout), 0);
    checkOutput("t1_no_mismatch", 32'(mm_seen), 0);
    @(negedge clk);

    // 0xFF + 0x01 with the KSA LSB flipped: reference 0x100 is forwarded.
    $display("[TB] forced mismatch recovery");
    runFaulted(8'hFF, 8'h01, 1'b0, 9'h001, 1'b0, 9'h100);

    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    cnt_model = 0;
    sticky_model = 1'b0;
    #1;
    checkOutput("clr_err_cnt", 32'(err_cnt), 0);
    checkOutput("clr_err_sticky", 32'(err_sticky), 0);
    @(negedge clk);

    // Back-to-back stream at full throughput.
    $display("[TB] 16-item stream");
    p0 = pops;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)), w);
      checkOutput("stream_in_rdy_wait", 32'(w), 0);
    end
    in_vld = 1'b0;
    waitDrain();
    checkOutput("stream_count", 32'(pops - p0), 16);

    // Back-pressure with both stages full.
    $display("[TB] back-pressure");
    out_rdy = 1'b0;
    applyStimulus(8'h10, 8'h20, 1'b0, w);
    applyStimulus(8'h80, 8'h80, 1'b1, w);
    a = 8'h01; b = 8'h02; cin = 1'b1; in_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("bp_in_rdy", 32'(in_rdy), 0);
      checkOutput("bp_out_vld", 32'(out_vld), 1);
      checkOutput("bp_hold", 32'({cout, sum}), 32'h030);
      @(negedge clk);
    end
    out_rdy = 1'b1;
    #1 checkOutput("bp_release_in_rdy", 32'(in_rdy), 1);
    @(negedge clk);
    in_vld = 1'b0;
    #1 checkOutput("bp_second", 32'({cout, sum}), 32'h101);
    @(negedge clk);
    #1 checkOutput("bp_third", 32'({cout, sum}), 32'h004);
    waitDrain();

    // Counter saturation at 3, then a clear coinciding with an event.
    $display("[TB] counter saturation");
    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      runFaulted(ra, rb, rc, masks[i], 1'b0, 9'(ra) + 9'(rb) + 9'(rc));
    end
    runFaulted(8'h12, 8'h34, 1'b0, 9'h002, 1'b1, 9'h046);

    // Reset while in RECOVER drops the item.
    $display("[TB] reset during recovery");
    fault_mask = 9'h001;
    a = 8'h33; b = 8'h44; cin = 1'b0; in_vld = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
    @(negedge clk);
    #1 checkOutput("rr_mismatch", 32'(mismatch), 1);
    exp_mm++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fault_mask = '0;
    cnt_model = 0;
    sticky_model = 1'b0;
    #1;
    checkOutput("rr_out_vld", 32'(out_vld), 0);
    checkOutput("rr_sum", 32'(sum), 0);
    checkOutput("rr_cout", 32'(cout), 0);
    checkOutput("rr_mismatch_clr", 32'(mismatch), 0);
    checkOutput("rr_err_cnt", 32'(err_cnt), 0);
    checkOutput("rr_err_sticky", 32'(err_sticky), 0);
    checkOutput("rr_in_rdy", 32'(in_rdy), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 checkOutput("rr_no_output", 32'(out_vld), 0);
    end

    checkOutput("mismatch_pulse_count", 32'(mm_seen), 32'(exp_mm));
    checkOutput("queue_empty_end", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog against a hung handshake.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
